// File: rtl/lsu_sequencer.sv
// lsu_sequencer: load/store sequencer between the core and a word-wide synchronous memory.
// Handles RV32I sub-word loads (lane extract + extend) and sub-word stores (read-modify-write).
module lsu_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d, err_q, err_d;
  logic [31:0]       wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
  logic              req_err;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_v, merged;

  assign req_err = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) | (req_we & req_funct3[2])
                 | ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00));

  // memory data is valid in RDW, so loads are extracted straight from mem_rdata
  assign byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign load_v = f3_q[0] ? {{16{half_v[15] & ~f3_q[2]}}, half_v}
                : f3_q[1] ? mem_rdata
                : {{24{byte_v[7] & ~f3_q[2]}}, byte_v};

  always_comb begin
    merged = word_q;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    if (f3_q[1:0] == 2'b01) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    if (f3_q[1]) merged = wdata_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        f3_d    = req_funct3;
        we_d    = req_we;
        err_d   = req_err;
        wdata_d = req_wdata;
        if (req_err) rdata_d = '0;
        state_d = req_err ? RESP : (req_we & req_funct3[1]) ? WR : RD;
      end
      RD:  state_d = RDW;
      RDW: begin
        word_d  = mem_rdata;
        rdata_d = we_q ? rdata_q : load_v;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;
  assign mem_re    = state_q == RD;
  assign mem_we    = state_q == WR;
  assign mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? merged : '0;
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed scenario tests for lsu_sequencer against a word-wide memory model.
module tb_lsu_sequencer;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err, busy, mem_re, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] mem [0:255];
  int vectors = 0, miscompares = 0, we_total = 0, rsp_total = 0, overlap = 0;
  int lat, re_cyc, we_cyc, re_cnt, we_cnt;
  logic [31:0] r_data, w_data, w_addr;
  logic        r_err;

  lsu_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we) we_total++;
    if (rsp_valid) rsp_total++;
    if (mem_re && mem_we) overlap++;
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b010; req_addr = ~addr; req_wdata = ~wd;
    lat = 0; re_cyc = 0; we_cyc = 0; re_cnt = 0; we_cnt = 0;
    r_data = 'x; r_err = 1'bx; w_data = '0; w_addr = '0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_re) begin re_cnt++; re_cyc = c; end
      if (mem_we) begin we_cnt++; we_cyc = c; w_data = mem_wdata; w_addr = mem_addr; end
      if (rsp_valid) begin lat = c; r_data = rsp_rdata; r_err = rsp_err; end
    end
    vectors++; if (lat == 0) begin miscompares++; $display("FAIL timeout: no rsp_valid within 10 cycles for f3=%b addr=%h", f3, addr); end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({req_ready, busy, rsp_valid, rsp_err, mem_re, mem_we} !== 6'b100000) begin miscompares++; $display("FAIL reset_flags got %b want 100000", {req_ready, busy, rsp_valid, rsp_err, mem_re, mem_we}); end
    vectors++; if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", {rsp_rdata, mem_addr, mem_wdata}); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({req_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL reset_release got %b want 10", {req_ready, busy}); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h103, 32'h100, 32'h102, 32'h102};
    logic [31:0] exps[4] = '{32'hFFFFFF87, 32'h000000F1, 32'hFFFF8765, 32'h00008765};
    mem[8'h40] = 32'h876543F1;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    vectors++; if (re_cyc !== 1) begin miscompares++; $display("FAIL lw_re_cycle got %0d want 1", re_cyc); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lw_latency got %0d want 3", lat); end
    vectors++; if (r_data !== 32'h876543F1) begin miscompares++; $display("FAIL lw_rdata got %h want 876543f1", r_data); end
    vectors++; if (re_cnt !== 1 || we_cnt !== 0 || r_err !== 1'b0) begin miscompares++; $display("FAIL lw_strobes got re=%0d we=%0d err=%b want 1 0 0", re_cnt, we_cnt, r_err); end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], ads[i], 32'h0);
      vectors++; if (r_data !== exps[i] || lat !== 3) begin miscompares++; $display("FAIL load_f3_%b got %h lat %0d want %h lat 3", f3s[i], r_data, lat, exps[i]); end
    end
  endtask

  task automatic test_errors;
    logic        wes[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s[4] = '{3'b001, 3'b010, 3'b100, 3'b011};
    logic [31:0] ads[4] = '{32'h101, 32'h102, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], ads[i], 32'hFFFFFFFF);
      vectors++; if (lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0) begin miscompares++; $display("FAIL err_%0d got lat %0d err %b rdata %h want lat 1 err 1 rdata 0", i, lat, r_err, r_data); end
      vectors++; if (re_cnt + we_cnt !== 0) begin miscompares++; $display("FAIL err_%0d_strobes got %0d want 0", i, re_cnt + we_cnt); end
    end
  endtask

  task automatic test_rmw;
    mem[8'h40] = 32'h876543F1;
    issue(1'b1, 3'b000, 32'h101, 32'h000000AA);
    vectors++; if (re_cnt !== 1 || re_cyc !== 1 || we_cnt !== 1 || we_cyc !== 3) begin miscompares++; $display("FAIL sb_strobes got re %0d@%0d we %0d@%0d want 1@1 1@3", re_cnt, re_cyc, we_cnt, we_cyc); end
    vectors++; if (w_data !== 32'h8765AAF1) begin miscompares++; $display("FAIL sb_wdata got %h want 8765aaf1", w_data); end
    vectors++; if (lat !== 4 || r_data !== 32'h0 || r_err !== 1'b0) begin miscompares++; $display("FAIL sb_rsp got lat %0d rdata %h err %b want 4 0 0", lat, r_data, r_err); end
    issue(1'b1, 3'b001, 32'h102, 32'h00001234);
    vectors++; if (w_data !== 32'h1234AAF1 || lat !== 4) begin miscompares++; $display("FAIL sh_wdata got %h lat %0d want 1234aaf1 lat 4", w_data, lat); end
    vectors++; if (mem[8'h40] !== 32'h1234AAF1) begin miscompares++; $display("FAIL sh_mem got %h want 1234aaf1", mem[8'h40]); end
  endtask

  task automatic test_sw;
    issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    vectors++; if (we_cyc !== 1 || we_cnt !== 1 || re_cnt !== 0) begin miscompares++; $display("FAIL sw_strobes got we %0d@%0d re %0d want 1@1 re 0", we_cnt, we_cyc, re_cnt); end
    vectors++; if (w_addr !== 32'h104 || w_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_write got %h=%h want 104=deadbeef", w_addr, w_data); end
    vectors++; if (lat !== 2 || mem[8'h41] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_rsp got lat %0d mem %h want 2 deadbeef", lat, mem[8'h41]); end
  endtask

  task automatic test_back_to_back;
    logic [8:1]  rdy, rv, re;
    logic [31:0] rd[1:8];
    mem[8'h40] = 32'h876543F1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy[c] = req_ready; rv[c] = rsp_valid; re[c] = mem_re; rd[c] = rsp_rdata;
      if (c == 3) req_funct3 = 3'b100;
      if (c == 7) req_valid = 1'b0;
    end
    vectors++; if (rdy[5:1] !== 5'b01000) begin miscompares++; $display("FAIL b2b_ready got %b want 01000", rdy[5:1]); end
    vectors++; if (rv !== 8'b01000100) begin miscompares++; $display("FAIL b2b_rsp_valid got %b want 01000100", rv); end
    vectors++; if (re !== 8'b00010001) begin miscompares++; $display("FAIL b2b_mem_re got %b want 00010001", re); end
    vectors++; if (rd[3] !== 32'h876543F1 || rd[7] !== 32'h000000F1) begin miscompares++; $display("FAIL b2b_rdata got %h %h want 876543f1 000000f1", rd[3], rd[7]); end
  endtask

  task automatic test_reset_mid;
    int we0, rsp0;
    mem[8'h40] = 32'h876543F1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", busy); end
    we0 = we_total; rsp0 = rsp_total;
    reset = 1'b1;
    #1;
    vectors++; if ({busy, mem_re, mem_we, req_ready} !== 4'b0001) begin miscompares++; $display("FAIL mid_async got %b want 0001", {busy, mem_re, mem_we, req_ready}); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (we_total !== we0 || rsp_total !== rsp0) begin miscompares++; $display("FAIL mid_no_strobe got we %0d rsp %0d want 0 0", we_total - we0, rsp_total - rsp0); end
    vectors++; if (mem[8'h40] !== 32'h876543F1 || req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_mem got %h ready %b want 876543f1 1", mem[8'h40], req_ready); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h876543F1;
    test_reset;
    test_loads;
    test_errors;
    test_rmw;
    test_sw;
    test_back_to_back;
    test_reset_mid;
    vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
